// File: rtl/dsp_iter_mant_mul_ctrl_if.sv
// Handshake and DSP48E1 pin bundle for the iterative mantissa multiplier sequencer.
// slave = controller side, master = environment (front end, consumer and slice).
interface dsp_iter_mant_mul_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] prod;
    logic        busy;
    logic [29:0] dsp_a;
    logic [17:0] dsp_b;
    logic [6:0]  dsp_opmode;
    logic [3:0]  dsp_alumode;
    logic [4:0]  dsp_inmode;
    logic [47:0] dsp_p;

    modport slave (
        input  in_valid, ma, mb, out_ready, dsp_p,
        output in_ready, out_valid, prod, busy,
               dsp_a, dsp_b, dsp_opmode, dsp_alumode, dsp_inmode
    );

    modport master (
        output in_valid, ma, mb, out_ready, dsp_p,
        input  in_ready, out_valid, prod, busy,
               dsp_a, dsp_b, dsp_opmode, dsp_alumode, dsp_inmode
    );
endinterface

// File: rtl/dsp_iter_mant_mul_ctrl.sv
// Two-pass unsigned 24x24 mantissa multiply through one DSP48E1 (AREG/BREG=2, MREG/PREG=1).
// Optional feature macro: DSPCTRL_STICKY_EN adds a sticky output registered with prod.
module dsp_iter_mant_mul_ctrl #(
    parameter int DSP_LAT  = 4,
    parameter int CTRL_DLY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dsp_iter_mant_mul_ctrl_if.slave bus
`ifdef DSPCTRL_STICKY_EN
    ,
    output logic                    sticky
`endif
);

    localparam logic [6:0] OPM_HOLD = 7'b0100000;
    localparam logic [6:0] OPM_LO   = 7'b0000101;
    localparam logic [6:0] OPM_HI   = 7'b1100101;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [4:0] INM_AB   = 5'b00000;

    localparam int              CNT_W  = $clog2(DSP_LAT);
    localparam logic [CNT_W-1:0] CNT_LO = CNT_W'(DSP_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_PR = CNT_W'(DSP_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISS_LO,
        S_ISS_HI,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_LO,
        SLOT_HI
    } slot_t;

    state_t           r_state;
    logic [23:0]      r_ma;
    logic [6:0]       r_mb_hi;
    logic [16:0]      r_lo17;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [47:0]      r_prod;
    logic [29:0]      r_dsp_a;
    logic [17:0]      r_dsp_b;
    slot_t            r_slot [CTRL_DLY];
    logic [6:0]       r_opmode;
    logic [3:0]       r_alumode;
    logic [4:0]       r_inmode;
`ifdef DSPCTRL_STICKY_EN
    logic             r_sticky;
`endif

    logic             w_accept;
    slot_t            w_slot_in;
    logic [47:0]      w_prod_next;
    logic             w_unused_p;

    assign w_accept    = (r_state == S_IDLE) && bus.in_valid && r_in_ready;
    // P holds (ma*mb) >> 17 after the HI pass; the low 17 bits came from the LO pass.
    assign w_prod_next = {bus.dsp_p[30:0], r_lo17};
    assign w_unused_p  = ^bus.dsp_p[47:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ma        <= '0;
            r_mb_hi     <= '0;
            r_lo17      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_prod      <= '0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
`ifdef DSPCTRL_STICKY_EN
            r_sticky    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ma       <= bus.ma;
                        r_mb_hi    <= bus.mb[23:17];
                        r_dsp_a    <= {6'b0, bus.ma};
                        r_dsp_b    <= {1'b0, bus.mb[16:0]};
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISS_LO;
                    end
                end
                S_ISS_LO: begin
                    r_dsp_a <= {6'b0, r_ma};
                    r_dsp_b <= {11'b0, r_mb_hi};
                    r_state <= S_ISS_HI;
                end
                S_ISS_HI: begin
                    r_dsp_a <= '0;
                    r_dsp_b <= '0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LO) begin
                        r_lo17 <= bus.dsp_p[16:0];
                    end
                    if (r_cnt == CNT_PR) begin
                        r_prod      <= w_prod_next;
`ifdef DSPCTRL_STICKY_EN
                        r_sticky    <= |w_prod_next[21:0];
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_slot_in = SLOT_NONE;
        if (w_accept) begin
            w_slot_in = SLOT_LO;
        end else if (r_state == S_ISS_LO) begin
            w_slot_in = SLOT_HI;
        end
    end

    // Control words travel with their issue slot so they meet the operands at the slice ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CTRL_DLY; i++) begin
                r_slot[i] <= SLOT_NONE;
            end
            r_opmode  <= OPM_HOLD;
            r_alumode <= ALU_ADD;
            r_inmode  <= INM_AB;
        end else begin
            r_slot[0] <= w_slot_in;
            for (int i = 1; i < CTRL_DLY; i++) begin
                r_slot[i] <= r_slot[i-1];
            end
            case (r_slot[CTRL_DLY-1])
                SLOT_LO: begin
                    r_opmode  <= OPM_LO;
                    r_alumode <= ALU_ADD;
                    r_inmode  <= INM_AB;
                end
                SLOT_HI: begin
                    r_opmode  <= OPM_HI;
                    r_alumode <= ALU_ADD;
                    r_inmode  <= INM_AB;
                end
                default: begin
                    r_opmode  <= OPM_HOLD;
                    r_alumode <= ALU_ADD;
                    r_inmode  <= INM_AB;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.prod        = r_prod;
    assign bus.busy        = r_busy;
    assign bus.dsp_a       = r_dsp_a;
    assign bus.dsp_b       = r_dsp_b;
    assign bus.dsp_opmode  = r_opmode;
    assign bus.dsp_alumode = r_alumode;
    assign bus.dsp_inmode  = r_inmode;
`ifdef DSPCTRL_STICKY_EN
    assign sticky          = r_sticky;
`endif

endmodule

// File: tb/tb_dsp_iter_mant_mul_ctrl.sv
// Bench for dsp_iter_mant_mul_ctrl: behavioural DSP48E1 slice, vector table, corner sequences, random ops.
// Build with DSPCTRL_STICKY_EN defined to also check the sticky output.
module tb_dsp_iter_mant_mul_ctrl;

    localparam logic [6:0] OPM_HOLD = 7'b0100000;
    localparam logic [6:0] OPM_LO   = 7'b0000101;
    localparam logic [6:0] OPM_HI   = 7'b1100101;
    localparam int         DSP_LAT  = 4;
    localparam int         CTRL_DLY = 2;
    localparam int         LAT      = DSP_LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dsp_iter_mant_mul_ctrl_if bus ();
`ifdef DSPCTRL_STICKY_EN
    logic sticky;
`endif

    dsp_iter_mant_mul_ctrl #(
        .DSP_LAT  (DSP_LAT),
        .CTRL_DLY (CTRL_DLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DSPCTRL_STICKY_EN
        ,
        .sticky (sticky)
`endif
    );

    // Slice model: two A/B stages, M, P, one control register; any unexpected control corrupts P.
    logic [29:0] a1, a2;
    logic [17:0] b1, b2;
    logic [47:0] mReg, pReg;
    logic [6:0]  opReg;
    logic [3:0]  aluReg;
    logic [4:0]  inReg;

    function automatic logic [47:0] sliceMult(input logic [24:0] a, input logic [17:0] b);
        logic signed [42:0] r;
        r = $signed(a) * $signed(b);
        return {{5{r[42]}}, r};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a1 <= '0; a2 <= '0; b1 <= '0; b2 <= '0;
            mReg <= '0; pReg <= '0;
            opReg <= OPM_HOLD; aluReg <= '0; inReg <= '0;
        end else begin
            a1 <= bus.dsp_a;  a2 <= a1;
            b1 <= bus.dsp_b;  b2 <= b1;
            mReg   <= sliceMult(a2[24:0], b2);
            opReg  <= bus.dsp_opmode;
            aluReg <= bus.dsp_alumode;
            inReg  <= bus.dsp_inmode;
            if (aluReg != 4'd0 || inReg != 5'd0) begin
                pReg <= ~pReg;
            end else begin
                case (opReg)
                    OPM_LO:   pReg <= mReg;
                    OPM_HI:   pReg <= mReg + (pReg >> 17);
                    OPM_HOLD: pReg <= pReg;
                    default:  pReg <= 48'hBAD0BAD0BAD0;
                endcase
            end
        end
    end
    assign bus.dsp_p = pReg;

    int nChecks = 0;
    int nFails  = 0;

    function automatic logic [47:0] refProduct(input logic [23:0] a, input logic [23:0] b);
        return 48'(a) * 48'(b);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("idle_reached", 64'(bus.in_ready), 64'(1'b1));
    endtask

    // Hands one pair over; returns in the first cycle after the accepting edge.
    task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b);
        waitIdle();
        bus.ma       = a;
        bus.mb       = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.ma       = 24'($urandom);
        bus.mb       = 24'($urandom);
    endtask

    task automatic waitResult(input int startLat, output int lat);
        lat = startLat;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [47:0] want, input int stall);
        int   lat;
        logic holdOk;
        bus.out_ready = (stall == 0);
        applyStimulus(a, b);
        checkOutput({tag, "_busy"}, 64'({bus.busy, bus.in_ready}), 64'(2'b10));
        waitResult(1, lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(LAT));
        checkOutput({tag, "_prod"}, 64'(bus.prod), 64'(want));
`ifdef DSPCTRL_STICKY_EN
        checkOutput({tag, "_sticky"}, 64'(sticky), 64'(|want[21:0]));
`endif
        holdOk = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.prod !== want) holdOk = 1'b0;
        end
        if (stall > 0) checkOutput({tag, "_stall_hold"}, 64'(holdOk), 64'(1'b1));
        bus.out_ready = 1'b1;
        tick();
        checkOutput({tag, "_release"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
    endtask

    typedef struct {
        logic [23:0] ma;
        logic [23:0] mb;
        logic [47:0] prod;
        int          stall;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          lat;
        int          seen;
        logic [6:0]  expOp;
        logic [23:0] ra, rb;

        vecs[0] = '{24'h800000, 24'h800000, 48'h400000000000, 0};
        vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0};
        vecs[2] = '{24'h000001, 24'h123456, 48'h000000123456, 10};
        vecs[3] = '{24'hC00000, 24'hC00000, 48'h900000000000, 2};
        vecs[4] = '{24'h000000, 24'hABCDEF, 48'h000000000000, 0};
        vecs[5] = '{24'h800001, 24'h800000, 48'h400000800000, 1};
        vecs[6] = '{24'h800000, 24'h820000, 48'h410000000000, 0};
        vecs[7] = '{24'h000002, 24'h01FFFF, 48'h00000003FFFE, 0};
        vecs[8] = '{24'hFFFFFF, 24'hFE0000, 48'hFDFFFF020000, 3};

        bus.in_valid  = 1'b0;
        bus.ma        = '0;
        bus.mb        = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_handshake", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
        checkOutput("reset_prod", 64'(bus.prod), 64'(0));
        checkOutput("reset_opmode", 64'(bus.dsp_opmode), 64'(OPM_HOLD));
        checkOutput("reset_pins", 64'({bus.dsp_a, bus.dsp_b, bus.dsp_alumode, bus.dsp_inmode}), 64'(0));
`ifdef DSPCTRL_STICKY_EN
        checkOutput("reset_sticky", 64'(sticky), 64'(1'b0));
`endif
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].ma, vecs[i].mb, vecs[i].prod, vecs[i].stall);
        end

        // Pin-level issue sequence for an all-ones pair.
        bus.out_ready = 1'b1;
        applyStimulus(24'hFFFFFF, 24'hFFFFFF);
        for (int k = 1; k <= LAT - 1; k++) begin
            expOp = (k == 1 + CTRL_DLY) ? OPM_LO : (k == 2 + CTRL_DLY) ? OPM_HI : OPM_HOLD;
            checkOutput($sformatf("seq_opmode_k%0d", k), 64'(bus.dsp_opmode), 64'(expOp));
            checkOutput($sformatf("seq_alu_in_k%0d", k), 64'({bus.dsp_alumode, bus.dsp_inmode}), 64'(0));
            if (k == 1) checkOutput("seq_pins_lo", 64'({bus.dsp_a, bus.dsp_b}), 64'({30'h00FFFFFF, 18'h1FFFF}));
            if (k == 2) checkOutput("seq_pins_hi", 64'({bus.dsp_a, bus.dsp_b}), 64'({30'h00FFFFFF, 18'h0007F}));
            tick();
        end
        checkOutput("seq_valid", 64'(bus.out_valid), 64'(1'b1));
        checkOutput("seq_prod", 64'(bus.prod), 64'(48'hFFFFFE000001));
        tick();
        checkOutput("seq_after_opmode", 64'(bus.dsp_opmode), 64'(OPM_HOLD));

        // Back-to-back accepts with in_valid held high.
        waitIdle();
        bus.out_ready = 1'b1;
        bus.ma        = 24'hC00000;
        bus.mb        = 24'hC00000;
        bus.in_valid  = 1'b1;
        tick();
        bus.ma = 24'h800001;
        bus.mb = 24'h7FFFFF;
        waitResult(1, lat);
        checkOutput("b2b_first_latency", 64'(lat), 64'(LAT));
        checkOutput("b2b_first_prod", 64'(bus.prod), 64'(48'h900000000000));
        tick();
        checkOutput("b2b_gap_idle", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
        tick();
        bus.in_valid = 1'b0;
        checkOutput("b2b_second_accept", 64'({bus.busy, bus.in_ready}), 64'(2'b10));
        waitResult(1, lat);
        checkOutput("b2b_second_latency", 64'(lat), 64'(LAT));
        checkOutput("b2b_second_prod", 64'(bus.prod), 64'(48'h3FFFFFFFFFFF));
        tick();

        // Reset asserted mid-operation.
        bus.out_ready = 1'b1;
        applyStimulus(24'h345678, 24'h9ABCDE);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstmid_handshake", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'(3'b100));
        checkOutput("rstmid_prod", 64'(bus.prod), 64'(0));
        checkOutput("rstmid_opmode", 64'(bus.dsp_opmode), 64'(OPM_HOLD));
        checkOutput("rstmid_pins", 64'({bus.dsp_a, bus.dsp_b}), 64'(0));
        tick();
        tick();
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1;
        end
        checkOutput("rstmid_no_valid", 64'(seen), 64'(0));
        runOp("post_rst", 24'hABCDEF, 24'h876543, refProduct(24'hABCDEF, 24'h876543), 0);

        // in_valid and operands wiggle while busy.
        bus.out_ready = 1'b1;
        applyStimulus(24'h000002, 24'h000003);
        seen = 0;
        for (int k = 1; k <= 5; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.ma       = 24'($urandom);
            bus.mb       = 24'($urandom);
            if (bus.in_ready !== 1'b0) seen = 1;
            tick();
        end
        bus.in_valid = 1'b0;
        checkOutput("toggle_in_ready_low", 64'(seen), 64'(0));
        waitResult(LAT - 1, lat);
        checkOutput("toggle_latency", 64'(lat), 64'(LAT));
        checkOutput("toggle_prod", 64'(bus.prod), 64'(48'h6));
        tick();
        checkOutput("toggle_release", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));

        for (int i = 0; i < 25; i++) begin
            ra = 24'($urandom) | (($urandom_range(0, 1) == 1) ? 24'h800000 : 24'h000000);
            rb = 24'($urandom) | 24'h800000;
            runOp($sformatf("rnd%0d", i), ra, rb, refProduct(ra, rb), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
